uart_tx_frame: RTL and testbench
================================

// Module: uart_tx_frame
// PURPOSE
//  Parametrised UART transmitter: serialises one DATA_W-bit word per frame as start, data LSB-first, optional parity, 1 or 2 stops.
//  Contains its own baud-tick divider, so the whole block runs in one clock domain; no external baud clock is needed.
//  Takes words from the UART TX FIFO or the CPU bus through a valid/ready handshake and drives the tx pad line.
// PARAMETERS
//  DATA_W   8   data bits per frame (5..9)
//  DIV_W   16   width of the baud divisor input
// PORTS
//  clk_i        in   1        system clock; the only clock in the block
//  rst_ni       in   1        asynchronous, active-low reset
//  tx_data_i    in   DATA_W   word to send
//  tx_valid_i   in   1        tx_data_i is valid
//  tx_ready_o   out  1        block is idle and accepts a word
//  baud_div_i   in   DIV_W    clocks per bit; 0 is treated as 1
//  parity_i     in   2        00 none, 01 even, 10 odd, 11 = none
//  stop2_i      in   1        0 = one stop bit, 1 = two stop bits
//  tx_o         out  1        serial line; idles high
//  busy_o       out  1        frame in progress
//  done_o       out  1        one-cycle pulse when a frame completes
// BEHAVIOUR
//  Reset (async, rst_ni=0): tx_o=1, tx_ready_o=1, busy_o=0, done_o=0; FSM goes to IDLE; all counters clear.
//  Reset mid-frame: tx_o returns high immediately, the frame is dropped, and no done_o pulse is issued.
//  Handshake: a word is accepted on a rising edge with tx_valid_i & tx_ready_o.
//   - At accept, tx_data_i, baud_div_i, parity_i and stop2_i are latched.
//   - Later changes to those inputs have no effect until the next accept.
//  tx_ready_o = (state==IDLE), registered; it drops the cycle after accept.
//  busy_o = ~tx_ready_o.
//  FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//   - IDLE:   tx_o=1. Goes to START on accept.
//   - START:  tx_o=0 for D cycles, where D = max(baud_div,1).
//   - DATA:   tx_o = shreg[0] for D cycles per bit; shifts right; bit counter runs 0..DATA_W-1.
//   - PARITY: entered only if parity mode is 01 or 10.
//       even: tx_o = ^data. odd: tx_o = ~^data. Lasts D cycles.
//   - STOP:   tx_o=1 for D cycles, or 2*D cycles if stop2 is set.
//  Baud counter: counts D-1 down to 0; at 0 the bit advances and the counter reloads.
//   - DIV_W arithmetic with no overflow; baud_div = 2^DIV_W-1 is legal.
//  Timing, with accept at edge T and NB = 1 + DATA_W + P + S bits (P = 0/1, S = 1/2):
//   - First start-bit cycle is T+1.
//   - Last stop cycle is T+NB*D.
//   - At T+NB*D+1: state is IDLE, tx_ready_o=1, done_o=1 for exactly one cycle.
//  Back-to-back: if tx_valid_i is high at T+NB*D+1, that word is accepted in the same cycle.
//   - Its start bit begins at T+NB*D+2, giving exactly one idle-high cycle between frames.
//  tx_valid_i while busy is ignored; the word stays pending at the source, which must hold it.
//  Outputs tx_o, tx_ready_o and done_o are registered; there are no combinational paths from inputs to outputs.
// TESTING
//  1. DATA_W=8, div=4, parity=00, stop2=0, word 0xA5 accepted at T.
//     -> tx_o reads 0,1,0,1,0,0,1,0,1,1, each level held 4 clocks; done_o at T+41.
//  2. Same word with parity=01 (even), then with parity=10 (odd).
//     -> parity bit is 0 for even and 1 for odd; done_o at T+45.
//  3. stop2=1, div=1, word 0x00, parity none.
//     -> tx_o is 0 for 9 cycles then 1 for 2 cycles; done_o at T+12.
//  4. tx_valid_i held high with 3 words queued, div=2.
//     -> exactly 1 idle-high cycle between frames; 3 done_o pulses spaced 21 cycles apart.
//  5. Change baud_div_i and parity_i mid-frame.
//     -> current frame keeps the latched settings; the next frame uses the new ones.
//     div=0 -> every bit lasts 1 cycle.
//  6. Assert rst_ni low in the DATA state.
//     -> tx_o=1 in the same cycle, no done_o pulse, tx_ready_o=1 after release; the next frame is sent correctly.

Source files
------------

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: UART transmitter with built-in baud divider, start/data/parity/stop framing
module uart_tx_frame #(
   parameter int DATA_W = 8,
   parameter int DIV_W  = 16
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic [DATA_W-1:0] tx_data_i,
   input  logic              tx_valid_i,
   output logic              tx_ready_o,
   input  logic [DIV_W-1:0]  baud_div_i,
   input  logic [1:0]        parity_i,
   input  logic              stop2_i,
   output logic              tx_o,
   output logic              busy_o,
   output logic              done_o
);
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
   state_t             state_q;
   logic [DATA_W-1:0]  sh_q;
   logic [DIV_W-1:0]   div_q, baud_q, div_d;
   logic [3:0]         bit_q;
   logic               par_q, par_en_q, stop2_q, tx_q, ready_q, done_q;
   logic               tick;
   assign div_d      = (baud_div_i == '0) ? DIV_W'(1) : baud_div_i;
   assign tick       = (baud_q == '0);
   assign tx_o       = tx_q;
   assign tx_ready_o = ready_q;
   assign busy_o     = ~ready_q;
   assign done_o     = done_q;
   // Frame sequencer: latches settings at accept, then walks each bit for div_q clocks
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         sh_q     <= '0;
         div_q    <= DIV_W'(1);
         baud_q   <= '0;
         bit_q    <= '0;
         par_q    <= 1'b0;
         par_en_q <= 1'b0;
         stop2_q  <= 1'b0;
         tx_q     <= 1'b1;
         ready_q  <= 1'b1;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (state_q == IDLE) begin
            if (tx_valid_i) begin
               state_q  <= START;
               sh_q     <= tx_data_i;
               div_q    <= div_d;
               baud_q   <= div_d - DIV_W'(1);
               par_q    <= parity_i[1] ? ~^tx_data_i : ^tx_data_i;
               par_en_q <= ^parity_i;
               stop2_q  <= stop2_i;
               tx_q     <= 1'b0;
               ready_q  <= 1'b0;
            end
         end else if (!tick) begin
            baud_q <= baud_q - DIV_W'(1);
         end else begin
            baud_q <= div_q - DIV_W'(1);
            unique case (state_q)
               START: begin
                  state_q <= DATA;
                  tx_q    <= sh_q[0];
                  bit_q   <= '0;
               end
               DATA: begin
                  if (bit_q == 4'(DATA_W - 1)) begin
                     state_q <= par_en_q ? PARITY : STOP;
                     tx_q    <= par_en_q ? par_q : 1'b1;
                     bit_q   <= {3'b000, stop2_q};
                  end else begin
                     sh_q  <= sh_q >> 1;
                     tx_q  <= sh_q[1];
                     bit_q <= bit_q + 4'd1;
                  end
               end
               PARITY: begin
                  state_q <= STOP;
                  tx_q    <= 1'b1;
               end
               STOP: begin
                  if (bit_q != '0) begin
                     bit_q <= bit_q - 4'd1;
                  end else begin
                     state_q <= IDLE;
                     ready_q <= 1'b1;
                     done_q  <= 1'b1;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: scoreboard bench for uart_tx_frame framing, timing, back-to-back and reset
module tb_uart_tx_frame;
   logic        clk = 1'b0;
   logic        rst_ni = 1'b0;
   logic [7:0]  tx_data_i = '0;
   logic        tx_valid_i = 1'b0;
   logic        tx_ready_o;
   logic [15:0] baud_div_i = 16'd1;
   logic [1:0]  parity_i = 2'b00;
   logic        stop2_i = 1'b0;
   logic        tx_o, busy_o, done_o;

   uart_tx_frame #(.DATA_W(8), .DIV_W(16)) dut (
      .clk_i(clk), .rst_ni(rst_ni), .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i),
      .tx_ready_o(tx_ready_o), .baud_div_i(baud_div_i), .parity_i(parity_i),
      .stop2_i(stop2_i), .tx_o(tx_o), .busy_o(busy_o), .done_o(done_o));

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] lvl;
      int          nb;
      int          d;
      bit          follow;
   } exp_t;

   exp_t sb[$];
   exp_t cur;
   int   vec = 0;
   int   errs = 0;
   bit   mon_en = 1'b1;
   bit   active = 1'b0;
   bit   chk_follow = 1'b0;
   bit   stray = 1'b0;
   int   idx = 0;

   task automatic chk(input string n, input logic a, input logic e);
      vec++;
      if (a !== e) begin
         errs++;
         $display("FAIL %s: got %b expected %b at %0t", n, a, e, $time);
      end
   endtask

   function automatic exp_t model(input logic [7:0] data, input logic [15:0] div,
                                  input logic [1:0] par, input logic s2, input bit f);
      exp_t e;
      e.lvl = '1;
      e.lvl[0] = 1'b0;
      for (int i = 0; i < 8; i++) e.lvl[1+i] = data[i];
      e.nb = 9;
      if (par == 2'b01) begin
         e.lvl[9] = ^data;
         e.nb++;
      end else if (par == 2'b10) begin
         e.lvl[9] = ~^data;
         e.nb++;
      end
      e.nb += s2 ? 2 : 1;
      e.d = (div == 16'd0) ? 1 : int'(div);
      e.follow = f;
      return e;
   endfunction

   // Monitor: each cycle after busy rises is matched against the popped expected frame
   always @(negedge clk) begin
      if (!rst_ni || !mon_en) begin
         active = 1'b0;
         chk_follow = 1'b0;
         stray = 1'b0;
      end else begin
         if (chk_follow) begin
            chk("b2b_restart", busy_o, 1'b1);
            chk_follow = 1'b0;
         end
         if (!busy_o) stray = 1'b0;
         if (!active && busy_o && !stray) begin
            if (sb.size() == 0) begin
               errs++;
               vec++;
               stray = 1'b1;
               $display("FAIL stray_frame: got busy 1 expected no frame at %0t", $time);
            end else begin
               cur = sb.pop_front();
               active = 1'b1;
               idx = 1;
            end
         end
         if (active) begin
            if (idx <= cur.nb * cur.d) begin
               chk("tx_bit", tx_o, cur.lvl[(idx-1)/cur.d]);
               chk("done_low", done_o, 1'b0);
               idx++;
            end else begin
               chk("done_pulse", done_o, 1'b1);
               chk("ready_back", tx_ready_o, 1'b1);
               chk("idle_tx", tx_o, 1'b1);
               chk_follow = cur.follow;
               active = 1'b0;
            end
         end
      end
   end

   task automatic send(input logic [7:0] data, input logic [15:0] div, input logic [1:0] par,
                       input logic s2, input bit follow, input bit hold);
      int n;
      sb.push_back(model(data, div, par, s2, follow));
      tx_data_i = data;
      baud_div_i = div;
      parity_i = par;
      stop2_i = s2;
      tx_valid_i = 1'b1;
      n = 0;
      while (!tx_ready_o && n < 5000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 5000) begin
         errs++;
         vec++;
         $display("FAIL accept_timeout: got ready 0 expected 1");
      end
      @(posedge clk);
      @(negedge clk);
      if (!hold) tx_valid_i = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((sb.size() != 0 || busy_o || active) && n < 5000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 5000) begin
         errs++;
         vec++;
         $display("FAIL idle_timeout: got busy %b expected 0", busy_o);
      end
      repeat (3) @(negedge clk);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_tx", tx_o, 1'b1);
      chk("rst_ready", tx_ready_o, 1'b1);
      chk("rst_busy", busy_o, 1'b0);
      chk("rst_done", done_o, 1'b0);
      rst_ni = 1'b1;
      repeat (2) @(negedge clk);
      send(8'hA5, 16'd4, 2'b00, 1'b0, 1'b0, 1'b0);
      wait_idle();
      send(8'hA5, 16'd4, 2'b01, 1'b0, 1'b0, 1'b0);
      wait_idle();
      send(8'hA5, 16'd4, 2'b10, 1'b0, 1'b0, 1'b0);
      wait_idle();
      send(8'h00, 16'd1, 2'b00, 1'b1, 1'b0, 1'b0);
      wait_idle();
      send(8'h3C, 16'd2, 2'b00, 1'b0, 1'b1, 1'b1);
      send(8'hC3, 16'd2, 2'b00, 1'b0, 1'b1, 1'b1);
      send(8'h81, 16'd2, 2'b00, 1'b0, 1'b0, 1'b0);
      wait_idle();
      send(8'h5A, 16'd3, 2'b01, 1'b0, 1'b0, 1'b0);
      repeat (8) @(negedge clk);
      baud_div_i = 16'd0;
      parity_i = 2'b10;
      tx_data_i = 8'hFF;
      stop2_i = 1'b1;
      wait_idle();
      send(8'hFF, 16'd0, 2'b10, 1'b1, 1'b0, 1'b0);
      wait_idle();
      mon_en = 1'b0;
      tx_data_i = 8'h00;
      baud_div_i = 16'd2;
      parity_i = 2'b00;
      stop2_i = 1'b0;
      tx_valid_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      tx_valid_i = 1'b0;
      repeat (4) @(negedge clk);
      chk("pre_rst_busy", busy_o, 1'b1);
      chk("pre_rst_tx_data0", tx_o, 1'b0);
      rst_ni = 1'b0;
      #1;
      chk("mid_rst_tx", tx_o, 1'b1);
      chk("mid_rst_ready", tx_ready_o, 1'b1);
      chk("mid_rst_done", done_o, 1'b0);
      repeat (2) @(negedge clk);
      rst_ni = 1'b1;
      for (int i = 0; i < 25; i++) begin
         @(negedge clk);
         chk("post_rst_done", done_o, 1'b0);
         chk("post_rst_ready", tx_ready_o, 1'b1);
         chk("post_rst_tx", tx_o, 1'b1);
      end
      mon_en = 1'b1;
      @(negedge clk);
      send(8'h96, 16'd3, 2'b01, 1'b1, 1'b0, 1'b0);
      wait_idle();
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end
endmodule
